// File: rtl/mod_acc.sv
// Modulo-MODULUS up/down accumulator with a one-entry valid/ready output stage.
// Optional wrap-event counter enabled by defining MOD_ACC_WRAPCNT_EN.
module mod_acc #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inc,
    input  logic             cin,
    input  logic             dir,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             wrap,
    output logic             err,
    output logic [7:0]       wrap_cnt
);

    localparam int EXT = WIDTH + 2;
    localparam logic [EXT-1:0] MOD_X = EXT'(MODULUS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             accept;
    logic [EXT-1:0]   acc_x, step_x, up_x, dn_x, res_x;
    logic             up_wrap, dn_wrap, bad_op, step_wrap, wrap_evt;
    logic             unused_hi;

    assign in_ready  = (state_q == EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == FULL);
    assign sum       = acc_q;
    assign wrap      = wrap_q;
    assign err       = err_q;

    // acc < MODULUS and step <= MODULUS, so one conditional correction reduces either direction.
    always_comb begin
        acc_x     = EXT'(acc_q);
        step_x    = EXT'(inc) + EXT'(cin);
        up_x      = acc_x + step_x;
        up_wrap   = (up_x >= MOD_X);
        dn_wrap   = (step_x > acc_x);
        dn_x      = dn_wrap ? (acc_x + MOD_X - step_x) : (acc_x - step_x);
        bad_op    = (EXT'(inc) >= MOD_X);
        step_wrap = dir ? dn_wrap : up_wrap;
        if (dir)
            res_x = dn_x;
        else
            res_x = up_wrap ? (up_x - MOD_X) : up_x;
    end

    assign unused_hi = ^res_x[EXT-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wrap_d   = wrap_q;
        err_d    = err_q;
        wrap_evt = 1'b0;
        if (clr) begin
            // clear wins over a same-cycle accept; that operand is dropped
            state_d = EMPTY;
            acc_d   = '0;
            wrap_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            state_d = FULL;
            if (bad_op) begin
                err_d  = 1'b1;
                wrap_d = 1'b0;
            end else begin
                err_d    = 1'b0;
                wrap_d   = step_wrap;
                wrap_evt = step_wrap;
                acc_d    = res_x[WIDTH-1:0];
            end
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

`ifdef MOD_ACC_WRAPCNT_EN
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    // saturating count of wrapping accepts, cleared together with the accumulator
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clr)
            wrap_cnt_d = '0;
        else if (wrap_evt && (wrap_cnt_q != 8'hFF))
            wrap_cnt_d = wrap_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            wrap_cnt_q <= '0;
        else
            wrap_cnt_q <= wrap_cnt_d;
    end

    assign wrap_cnt = wrap_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = wrap_evt;
    assign wrap_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_mod_acc.sv
// Bench for mod_acc: modulo-arithmetic reference model checked every cycle
// on a WIDTH=4/MODULUS=10 instance, plus literal checks and a WIDTH=2/MODULUS=4 instance.
module tb_mod_acc;

    localparam int M = 10;

    logic       clk, rst;
    logic       in_valid, cin, dir, clr, out_ready;
    logic [3:0] inc;
    logic       in_ready, out_valid, wrap, err;
    logic [3:0] sum;
    logic [7:0] wrap_cnt;

    logic       s_in_valid, s_cin;
    logic [1:0] s_inc;
    logic       s_in_ready, s_out_valid, s_wrap, s_err;
    logic [1:0] s_sum;
    logic [7:0] s_wrap_cnt;

    int checks = 0;
    int errors = 0;

    mod_acc #(.WIDTH(4), .MODULUS(M)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inc(inc), .cin(cin), .dir(dir), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .wrap(wrap), .err(err), .wrap_cnt(wrap_cnt)
    );

    mod_acc #(.WIDTH(2), .MODULUS(4)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .inc(s_inc), .cin(s_cin), .dir(1'b0), .clr(1'b0),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .sum(s_sum), .wrap(s_wrap), .err(s_err), .wrap_cnt(s_wrap_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer modulo arithmetic
    int m_valid, m_sum, m_wrap, m_err, m_cnt;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        int t;
        int take;
        if (rst) begin
            m_valid = 0; m_sum = 0; m_wrap = 0; m_err = 0; m_cnt = 0;
            chk_en  = 1'b1;
        end else begin
            take = (in_valid && (m_valid == 0 || out_ready)) ? 1 : 0;
            if (clr) begin
                m_valid = 0; m_sum = 0; m_wrap = 0; m_err = 0; m_cnt = 0;
            end else if (take != 0) begin
                m_valid = 1;
                if (int'(inc) >= M) begin
                    m_err = 1; m_wrap = 0;
                end else begin
                    m_err = 0;
                    if (dir) t = m_sum - int'(inc) - int'(cin);
                    else     t = m_sum + int'(inc) + int'(cin);
                    m_wrap = (t < 0 || t >= M) ? 1 : 0;
                    m_sum  = ((t % M) + M) % M;
`ifdef MOD_ACC_WRAPCNT_EN
                    if (m_wrap != 0 && m_cnt < 255) m_cnt++;
`endif
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", int'(out_valid), m_valid);
            chk("in_ready", int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
            chk("sum", int'(sum), m_sum);
            chk("wrap_cnt", int'(wrap_cnt), m_cnt);
            if (m_valid != 0) begin
                chk("wrap", int'(wrap), m_wrap);
                chk("err", int'(err), m_err);
            end
        end
    end

    // Drive one cycle of inputs, then return 2 time units after the edge
    task automatic cyc(input logic v, input logic [3:0] i, input logic c, input logic d,
                       input logic cl, input logic r);
        in_valid = v; inc = i; cin = c; dir = d; clr = cl; out_ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; inc = 0; cin = 0; dir = 0; clr = 0; out_ready = 1;
        s_in_valid = 0; s_inc = 0; s_cin = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset sum", int'(sum), 0);
        chk("reset wrap_cnt", int'(wrap_cnt), 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 1);
        chk("in_ready after reset", int'(in_ready), 1);

        // small instance: reach acc=3, then 3+0+1 wraps to 0
        s_in_valid = 1; s_inc = 2'd3; s_cin = 0;
        cyc(0, 0, 0, 0, 0, 1);
        s_inc = 2'd0; s_cin = 1;
        cyc(0, 0, 0, 0, 0, 1);
        s_in_valid = 0;
        chk("small sum", int'(s_sum), 0);
        chk("small wrap", int'(s_wrap), 1);
        chk("small err", int'(s_err), 0);
        chk("small out_valid", int'(s_out_valid), 1);

        // acc=2, down by 5 -> 7 wrap, up by 3 -> 0 wrap
        cyc(1, 4'd2, 0, 0, 0, 1);
        chk("acc 2", int'(sum), 2);
        cyc(1, 4'd5, 0, 1, 0, 1);
        chk("down sum", int'(sum), 7);
        chk("down wrap", int'(wrap), 1);
        cyc(1, 4'd3, 0, 0, 0, 1);
        chk("up sum", int'(sum), 0);
        chk("up wrap", int'(wrap), 1);

        // out-of-range operand, then a no-op step
        cyc(1, 4'd12, 0, 0, 0, 1);
        chk("bad op err", int'(err), 1);
        chk("bad op wrap", int'(wrap), 0);
        chk("bad op sum", int'(sum), 0);
        cyc(1, 4'd0, 0, 0, 0, 1);
        chk("noop wrap", int'(wrap), 0);
        chk("noop err", int'(err), 0);

        // stall three cycles, then handoff and back-to-back
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 4'd4, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 4'd7, 0, 0, 0, 0);
            chk("stall sum", int'(sum), 4);
            chk("stall in_ready", int'(in_ready), 0);
        end
        cyc(1, 4'd7, 0, 0, 0, 1);
        chk("handoff sum", int'(sum), 1);
        cyc(1, 4'd2, 0, 0, 0, 1);
        chk("b2b sum", int'(sum), 3);

        // clr with same-cycle accept at acc=5
        cyc(1, 4'd2, 0, 0, 0, 1);
        chk("acc 5", int'(sum), 5);
        cyc(1, 4'd3, 0, 0, 1, 1);
        chk("clr sum", int'(sum), 0);
        chk("clr out_valid", int'(out_valid), 0);

        // reset while FULL
        cyc(1, 4'd6, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst full out_valid", int'(out_valid), 0);
        chk("rst full sum", int'(sum), 0);

        // boundary steps: 0-0-1 -> 9, then 9+9+1 -> 9
        cyc(1, 4'd0, 1, 1, 0, 1);
        chk("borrow sum", int'(sum), 9);
        cyc(1, 4'd9, 1, 0, 0, 1);
        chk("max step sum", int'(sum), 9);
        chk("max step wrap", int'(wrap), 1);

        // 260 more wrapping accepts (step = MODULUS)
        for (int k = 0; k < 260; k++) cyc(1, 4'd9, 1, 0, 0, 1);
`ifdef MOD_ACC_WRAPCNT_EN
        chk("wrap_cnt saturated", int'(wrap_cnt), 255);
`else
        chk("wrap_cnt absent", int'(wrap_cnt), 0);
`endif
        cyc(0, 0, 0, 0, 1, 1);
        chk("wrap_cnt after clr", int'(wrap_cnt), 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
